// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//   Decode-to-Execute pipeline register of the RV32IM 5-stage core. Captures
//   the decoded control word, register-file read data, sign-extended immediate
//   and PC values from ID and presents them to EX one cycle later. The hazard
//   unit can hold the stage (stall_e) or replace its contents with a bubble
//   (flush_e). Two saturating counters record stall and bubble cycles for
//   performance debug.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   stall_e, flush_e      hazard-unit hold / bubble requests (flush wins)
//   *_d                   decoded instruction fields from ID
//   *_e                   registered copies of the *_d fields, incl. valid_e
//   stall_cnt             cycles with stall_e=1 and flush_e=0 (saturating)
//   bubble_cnt            cycles with flush_e=1 (saturating)
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int XLEN     = 32,
    parameter int ALUCTL_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_e,
    input  logic                flush_e,
    input  logic                valid_d,
    input  logic                reg_write_d,
    input  logic [1:0]          result_src_d,
    input  logic                mem_write_d,
    input  logic                jump_d,
    input  logic                branch_d,
    input  logic                alu_src_d,
    input  logic [ALUCTL_W-1:0] alu_ctl_d,
    input  logic [2:0]          funct3_d,
    input  logic [XLEN-1:0]     rd1_d,
    input  logic [XLEN-1:0]     rd2_d,
    input  logic [XLEN-1:0]     imm_ext_d,
    input  logic [XLEN-1:0]     pc_d,
    input  logic [XLEN-1:0]     pc4_d,
    input  logic [4:0]          rs1_d,
    input  logic [4:0]          rs2_d,
    input  logic [4:0]          rd_d,
    output logic                valid_e,
    output logic                reg_write_e,
    output logic [1:0]          result_src_e,
    output logic                mem_write_e,
    output logic                jump_e,
    output logic                branch_e,
    output logic                alu_src_e,
    output logic [ALUCTL_W-1:0] alu_ctl_e,
    output logic [2:0]          funct3_e,
    output logic [XLEN-1:0]     rd1_e,
    output logic [XLEN-1:0]     rd2_e,
    output logic [XLEN-1:0]     imm_ext_e,
    output logic [XLEN-1:0]     pc_e,
    output logic [XLEN-1:0]     pc4_e,
    output logic [4:0]          rs1_e,
    output logic [4:0]          rs2_e,
    output logic [4:0]          rd_e,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    // Only a real instruction may carry state-committing controls into EX.
    logic commit_ok;
    assign commit_ok = valid_d;

    // Flush and reset both produce an all-zero slot, so they share one branch.
    // On stall nothing is written, which also keeps X on *_d out of the stage.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            valid_e      <= 1'b0;
            reg_write_e  <= 1'b0;
            result_src_e <= '0;
            mem_write_e  <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            alu_src_e    <= 1'b0;
            alu_ctl_e    <= '0;
            funct3_e     <= '0;
            rd1_e        <= '0;
            rd2_e        <= '0;
            imm_ext_e    <= '0;
            pc_e         <= '0;
            pc4_e        <= '0;
            rs1_e        <= '0;
            rs2_e        <= '0;
            rd_e         <= '0;
        end else if (!stall_e) begin
            valid_e      <= valid_d;
            reg_write_e  <= reg_write_d & commit_ok;
            result_src_e <= result_src_d;
            mem_write_e  <= mem_write_d & commit_ok;
            jump_e       <= jump_d & commit_ok;
            branch_e     <= branch_d & commit_ok;
            alu_src_e    <= alu_src_d;
            alu_ctl_e    <= alu_ctl_d;
            funct3_e     <= funct3_d;
            rd1_e        <= rd1_d;
            rd2_e        <= rd2_d;
            imm_ext_e    <= imm_ext_d;
            pc_e         <= pc_d;
            pc4_e        <= pc4_d;
            rs1_e        <= rs1_d;
            rs2_e        <= rs2_d;
            rd_e         <= rd_d;
        end
    end

    // Performance counters: index 0 counts stall cycles, index 1 bubbles.
    // A flush that coincides with a stall counts only as a bubble.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = stall_e & ~flush_e;
    assign cnt_inc[1] = flush_e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt  = cnt_reg[0];
    assign bubble_cnt = cnt_reg[1];

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [4:0]  alu_ctl;
        logic [2:0]  funct3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } fields_t;

    logic    clk = 1'b0;
    logic    rst, stall_e, flush_e;
    fields_t d_in;

    logic    valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [4:0]  alu_ctl_e, rs1_e, rs2_e, rd_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc4_e;
    logic [15:0] stall_cnt, bubble_cnt;

    logic    s_valid_e, s_reg_write_e, s_mem_write_e, s_jump_e, s_branch_e, s_alu_src_e;
    logic [1:0]  s_result_src_e;
    logic [4:0]  s_alu_ctl_e, s_rs1_e, s_rs2_e, s_rd_e;
    logic [2:0]  s_funct3_e;
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_ext_e, s_pc_e, s_pc4_e;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    fields_t obs, obs4;
    assign obs  = {valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e,
                   alu_src_e, alu_ctl_e, funct3_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc4_e,
                   rs1_e, rs2_e, rd_e};
    assign obs4 = {s_valid_e, s_reg_write_e, s_result_src_e, s_mem_write_e, s_jump_e,
                   s_branch_e, s_alu_src_e, s_alu_ctl_e, s_funct3_e, s_rd1_e, s_rd2_e,
                   s_imm_ext_e, s_pc_e, s_pc4_e, s_rs1_e, s_rs2_e, s_rd_e};

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(d_in.valid), .reg_write_d(d_in.reg_write), .result_src_d(d_in.result_src),
        .mem_write_d(d_in.mem_write), .jump_d(d_in.jump), .branch_d(d_in.branch),
        .alu_src_d(d_in.alu_src), .alu_ctl_d(d_in.alu_ctl), .funct3_d(d_in.funct3),
        .rd1_d(d_in.rd1), .rd2_d(d_in.rd2), .imm_ext_d(d_in.imm), .pc_d(d_in.pc),
        .pc4_d(d_in.pc4), .rs1_d(d_in.rs1), .rs2_d(d_in.rs2), .rd_d(d_in.rd),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
        .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
        .alu_src_e(alu_src_e), .alu_ctl_e(alu_ctl_e), .funct3_e(funct3_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc4_e(pc4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Same inputs, 4-bit counters, to reach saturation quickly.
    id_ex_pipeline_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(d_in.valid), .reg_write_d(d_in.reg_write), .result_src_d(d_in.result_src),
        .mem_write_d(d_in.mem_write), .jump_d(d_in.jump), .branch_d(d_in.branch),
        .alu_src_d(d_in.alu_src), .alu_ctl_d(d_in.alu_ctl), .funct3_d(d_in.funct3),
        .rd1_d(d_in.rd1), .rd2_d(d_in.rd2), .imm_ext_d(d_in.imm), .pc_d(d_in.pc),
        .pc4_d(d_in.pc4), .rs1_d(d_in.rs1), .rs2_d(d_in.rs2), .rd_d(d_in.rd),
        .valid_e(s_valid_e), .reg_write_e(s_reg_write_e), .result_src_e(s_result_src_e),
        .mem_write_e(s_mem_write_e), .jump_e(s_jump_e), .branch_e(s_branch_e),
        .alu_src_e(s_alu_src_e), .alu_ctl_e(s_alu_ctl_e), .funct3_e(s_funct3_e),
        .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .imm_ext_e(s_imm_ext_e), .pc_e(s_pc_e),
        .pc4_e(s_pc4_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    // Reference model: the contents of the E slot and the two counter values.
    fields_t exp_e;
    int      exp_stall, exp_bubble, exp_stall4, exp_bubble4;
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic fields_t rand_fields();
        fields_t r;
        r.valid      = 1'($urandom);
        r.reg_write  = 1'($urandom);
        r.result_src = 2'($urandom);
        r.mem_write  = 1'($urandom);
        r.jump       = 1'($urandom);
        r.branch     = 1'($urandom);
        r.alu_src    = 1'($urandom);
        r.alu_ctl    = 5'($urandom);
        r.funct3     = 3'($urandom);
        r.rd1        = $urandom;
        r.rd2        = $urandom;
        r.imm        = $urandom;
        r.pc         = $urandom;
        r.pc4        = r.pc + 32'd4;
        r.rs1        = 5'($urandom);
        r.rs2        = 5'($urandom);
        r.rd         = 5'($urandom);
        return r;
    endfunction

    function automatic int sat_inc(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Advance one clock edge and apply the block's rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_e = '0;
            exp_stall = 0; exp_bubble = 0; exp_stall4 = 0; exp_bubble4 = 0;
        end else if (flush_e) begin
            exp_e = '0;
            exp_bubble  = sat_inc(exp_bubble, 65535);
            exp_bubble4 = sat_inc(exp_bubble4, 15);
        end else if (stall_e) begin
            exp_stall  = sat_inc(exp_stall, 65535);
            exp_stall4 = sat_inc(exp_stall4, 15);
        end else begin
            exp_e = d_in;
            if (!d_in.valid) begin
                exp_e.reg_write = 1'b0;
                exp_e.mem_write = 1'b0;
                exp_e.jump      = 1'b0;
                exp_e.branch    = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_e = 1'($urandom); flush_e = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            d_in = rand_fields();
            tick();
            n_checks++;
            if (obs !== 192'(0) >> 1) begin
                n_fail++; $display("FAIL reset_fields got=%h want=0", obs);
            end
            n_checks++;
            if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0 || valid_e !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_cnt got stall=%0d bubble=%0d valid=%b want 0/0/0",
                         stall_cnt, bubble_cnt, valid_e);
            end
        end
        $display("test_reset: done");
    endtask

    fields_t addi;

    task automatic test_load_addi();
        rst = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        addi = rand_fields();
        addi.valid = 1'b1; addi.reg_write = 1'b1;
        addi.imm = 32'hFFFF_FFFB; addi.rd1 = 32'd7; addi.rd = 5'd5;
        d_in = addi;
        tick();
        n_checks++;
        if (imm_ext_e !== 32'hFFFF_FFFB || rd1_e !== 32'd7 || rd_e !== 5'd5 ||
            reg_write_e !== 1'b1 || valid_e !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_load got imm=%h rd1=%0d rd=%0d rw=%b v=%b want fffffffb/7/5/1/1",
                     imm_ext_e, rd1_e, rd_e, reg_write_e, valid_e);
        end
        n_checks++;
        if (obs !== addi) begin
            n_fail++; $display("FAIL addi_fields got=%h want=%h", obs, addi);
        end
        $display("test_load_addi: done");
    endtask

    task automatic test_stall();
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = (i == 1) ? 'x : rand_fields();
            tick();
            n_checks++;
            if (obs !== addi) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, obs, addi);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd3 || bubble_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_cnt got stall=%0d bubble=%0d want 3/0", stall_cnt, bubble_cnt);
        end
        $display("test_stall: done");
    endtask

    task automatic test_stall_flush();
        stall_e = 1'b1; flush_e = 1'b1;
        d_in = rand_fields(); d_in.valid = 1'b1; d_in.reg_write = 1'b1;
        d_in.imm = d_in.imm | 32'h1;
        tick();
        n_checks++;
        if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || imm_ext_e !== 32'd0 || obs !== exp_e) begin
            n_fail++;
            $display("FAIL flush_bubble got v=%b rw=%b imm=%h fields=%h want all zero",
                     valid_e, reg_write_e, imm_ext_e, obs);
        end
        n_checks++;
        if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL flush_cnt got bubble=%0d stall=%0d want 1/3", bubble_cnt, stall_cnt);
        end
        flush_e = 1'b0;
        $display("test_stall_flush: done");
    endtask

    task automatic test_saturation();
        stall_e = 1'b1; flush_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d_in = rand_fields();
            tick();
            n_checks++;
            if (s_stall_cnt !== 4'(exp_stall4) || stall_cnt !== 16'(exp_stall)) begin
                n_fail++;
                $display("FAIL sat_step cyc=%0d got small=%0d big=%0d want %0d/%0d",
                         i, s_stall_cnt, stall_cnt, exp_stall4, exp_stall);
            end
        end
        n_checks++;
        if (s_stall_cnt !== 4'd15 || s_bubble_cnt !== 4'd1 || stall_cnt !== 16'd23) begin
            n_fail++;
            $display("FAIL sat_final got small=%0d bub=%0d big=%0d want 15/1/23",
                     s_stall_cnt, s_bubble_cnt, stall_cnt);
        end
        $display("test_saturation: done");
    endtask

    task automatic test_reset_mid_stall();
        fields_t ld;
        rst = 1'b1; stall_e = 1'b0; d_in = rand_fields();
        tick();
        rst = 1'b0; stall_e = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d_in = rand_fields(); tick();
        end
        n_checks++;
        if (stall_cnt !== 16'd9) begin
            n_fail++; $display("FAIL pre_rst_cnt got=%0d want=9", stall_cnt);
        end
        rst = 1'b1; d_in = rand_fields();
        tick();
        n_checks++;
        if (obs !== exp_e || valid_e !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_stall got=%h cnt=%0d want zero", obs, stall_cnt);
        end
        rst = 1'b0; stall_e = 1'b0;
        ld = rand_fields(); ld.valid = 1'b1; d_in = ld;
        tick();
        n_checks++;
        if (obs !== ld) begin
            n_fail++; $display("FAIL post_rst_load got=%h want=%h", obs, ld);
        end
        d_in = rand_fields(); d_in.valid = 1'b0; d_in.mem_write = 1'b1;
        d_in.reg_write = 1'b1; d_in.jump = 1'b1; d_in.branch = 1'b1;
        ld = d_in;
        tick();
        n_checks++;
        if (mem_write_e !== 1'b0 || reg_write_e !== 1'b0 || jump_e !== 1'b0 ||
            branch_e !== 1'b0 || rd1_e !== ld.rd1 || valid_e !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_gate got mw=%b rw=%b j=%b b=%b rd1=%h want 0/0/0/0/%h",
                     mem_write_e, reg_write_e, jump_e, branch_e, rd1_e, ld.rd1);
        end
        $display("test_reset_mid_stall: done");
    endtask

    task automatic test_back_to_back();
        fields_t prev;
        rst = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prev = rand_fields(); prev.valid = 1'b1; d_in = prev;
            tick();
            n_checks++;
            if (obs !== prev) begin
                n_fail++; $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs, prev);
            end
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst     = ($urandom_range(0, 39) == 0);
            flush_e = ($urandom_range(0, 6) == 0);
            stall_e = ($urandom_range(0, 3) == 0);
            d_in    = stall_e && !flush_e && ($urandom_range(0, 3) == 0) ? 'x : rand_fields();
            tick();
            n_checks++;
            if (obs !== exp_e || obs4 !== exp_e) begin
                n_fail++; $display("FAIL rand_fields cyc=%0d got=%h want=%h", i, obs, exp_e);
            end
            n_checks++;
            if (stall_cnt !== 16'(exp_stall) || bubble_cnt !== 16'(exp_bubble) ||
                s_stall_cnt !== 4'(exp_stall4) || s_bubble_cnt !== 4'(exp_bubble4)) begin
                n_fail++;
                $display("FAIL rand_cnt cyc=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                         stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt,
                         exp_stall, exp_bubble, exp_stall4, exp_bubble4);
            end
        end
        $display("test_random: done");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        exp_e = '0;
        exp_stall = 0; exp_bubble = 0; exp_stall4 = 0; exp_bubble4 = 0;
        rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0; d_in = '0;
        test_reset();
        test_load_addi();
        test_stall();
        test_stall_flush();
        test_saturation();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
